// File: rtl/segmented_sieve_if.sv
// Range-query handshake bundle for the segmented prime sieve.
interface segmented_sieve_if #(
  parameter int N_W = 14
);
  logic           start;
  logic [N_W-1:0] lo;
  logic [N_W-1:0] hi;
  logic           busy;
  logic           prime_valid;
  logic           prime_ready;
  logic [N_W-1:0] prime_data;
  logic           done;
  logic           err;
  logic [N_W-1:0] count;

  modport master (
    output start, lo, hi, prime_ready,
    input  busy, prime_valid, prime_data, done, err, count
  );

  modport slave (
    input  start, lo, hi, prime_ready,
    output busy, prime_valid, prime_data, done, err, count
  );
endinterface

// File: rtl/segmented_sieve.sv
// Streaming segmented sieve of Eratosthenes over a run-time range [lo, hi].
// Each base prime keeps a next-multiple register that persists across segments.
module segmented_sieve #(
  parameter int N_W      = 14,
  parameter int MAX_N    = 10000,
  parameter int SEG_LEN  = 64,
  parameter int P_W      = 7,
  parameter int NUM_BASE = 25,
  parameter logic [NUM_BASE*P_W-1:0] BASE_PRIMES = {
    7'd97, 7'd89, 7'd83, 7'd79, 7'd73, 7'd71, 7'd67, 7'd61, 7'd59,
    7'd53, 7'd47, 7'd43, 7'd41, 7'd37, 7'd31, 7'd29, 7'd23, 7'd19,
    7'd17, 7'd13, 7'd11, 7'd7,  7'd5,  7'd3,  7'd2}
) (
  input  logic              clk,
  input  logic              rst,
  segmented_sieve_if.slave  bus
);

  localparam int SEG_W = $clog2(SEG_LEN);
  localparam int K_W   = $clog2(NUM_BASE);
  localparam int DC_W  = $clog2(N_W + 1);

  localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM_BASE - 1);
  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(N_W);
  localparam logic [SEG_W-1:0] PTR_LAST = '1;
  localparam logic [N_W:0]     MAX_V    = (N_W+1)'(MAX_N);
  localparam logic [N_W:0]     SPAN     = (N_W+1)'(SEG_LEN - 1);
  localparam logic [N_W:0]     STEP     = (N_W+1)'(SEG_LEN);
  localparam logic [N_W:0]     TWO      = (N_W+1)'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_MOD, S_SEG_INIT, S_SIEVE, S_EMIT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [N_W-1:0]     lo_q, hi_q, seg_base, count_q;
  logic               err_q;
  logic [N_W-1:0]     lo_sh;
  logic [P_W:0]       rem;
  logic [DC_W-1:0]    div_cnt;
  logic [K_W-1:0]     k;
  logic [N_W:0]       nxt [NUM_BASE];
  logic [SEG_LEN-1:0] bitmap;
  logic [SEG_W-1:0]   ptr;
  logic [P_W-1:0]     base_tab [NUM_BASE];

  logic [P_W:0]       p_ext, rem_sh;
  logic [N_W:0]       p_sq, nxt_k, seg_lim, seg_end, base_nx;
  logic [SEG_W-1:0]   off;
  logic               range_bad, mark, last_seg, emit_adv, pv;

  // Unpack the base-prime table into addressable entries
  always_comb begin
    for (int unsigned i = 0; i < NUM_BASE; i++) begin
      base_tab[i] = BASE_PRIMES[i*P_W +: P_W];
    end
  end

  // Shared datapath terms: current prime, division step, segment limits
  always_comb begin
    p_ext     = {1'b0, base_tab[k]};
    p_sq      = (N_W+1)'(p_ext) * (N_W+1)'(p_ext);
    rem_sh    = {rem[P_W-1:0], lo_sh[N_W-1]};
    nxt_k     = nxt[k];
    seg_lim   = {1'b0, seg_base} + SPAN;
    seg_end   = (seg_lim > {1'b0, hi_q}) ? {1'b0, hi_q} : seg_lim;
    base_nx   = {1'b0, seg_base} + STEP;
    // Overflow of seg_base shows up as the carry bit of base_nx
    last_seg  = base_nx[N_W] || (base_nx[N_W-1:0] > hi_q);
    mark      = (nxt_k <= seg_end);
    off       = SEG_W'(nxt_k - {1'b0, seg_base});
    range_bad = (bus.lo > bus.hi) || ({1'b0, bus.hi} > MAX_V);
    pv        = (state == S_EMIT) && bitmap[ptr];
    emit_adv  = !bitmap[ptr] || bus.prime_ready;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (bus.start) state_nx = range_bad ? S_DONE : S_MOD;
      S_MOD:      if (div_cnt == DC_LAST && k == K_LAST) state_nx = S_SEG_INIT;
      S_SEG_INIT: state_nx = S_SIEVE;
      S_SIEVE:    if (!mark && k == K_LAST) state_nx = S_EMIT;
      S_EMIT:     if (emit_adv && ptr == PTR_LAST) state_nx = last_seg ? S_DONE : S_SEG_INIT;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.busy        = (state != S_IDLE);
    bus.done        = (state == S_DONE);
    bus.err         = (state == S_DONE) && err_q;
    bus.prime_valid = pv;
    bus.prime_data  = pv ? (seg_base + N_W'(ptr)) : '0;
    bus.count       = count_q;
  end

  // Datapath: range latch, serial mod, segment bitmap, marking and scan
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
      k       <= '0;
      div_cnt <= '0;
      rem     <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            lo_q     <= bus.lo;
            hi_q     <= bus.hi;
            seg_base <= bus.lo;
            lo_sh    <= bus.lo;
            count_q  <= '0;
            err_q    <= range_bad;
            k        <= '0;
            div_cnt  <= '0;
            rem      <= '0;
          end
        end
        S_MOD: begin
          if (div_cnt == DC_LAST) begin
            if ({1'b0, lo_q} <= p_sq) nxt[k] <= p_sq;
            else if (rem == '0)       nxt[k] <= {1'b0, lo_q};
            else                      nxt[k] <= {1'b0, lo_q} + (N_W+1)'(p_ext - rem);
            div_cnt <= '0;
            rem     <= '0;
            lo_sh   <= lo_q;
            k       <= (k == K_LAST) ? '0 : k + 1'b1;
          end else begin
            lo_sh   <= lo_sh << 1;
            rem     <= (rem_sh >= p_ext) ? rem_sh - p_ext : rem_sh;
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_SEG_INIT: begin
          for (int unsigned i = 0; i < SEG_LEN; i++) begin
            bitmap[i] <= (({1'b0, seg_base} + (N_W+1)'(i)) >= TWO) &&
                         (({1'b0, seg_base} + (N_W+1)'(i)) <= seg_end);
          end
          ptr <= '0;
          k   <= '0;
        end
        S_SIEVE: begin
          if (mark) begin
            bitmap[off] <= 1'b0;
            nxt[k]      <= nxt_k + (N_W+1)'(p_ext);
          end else begin
            k <= (k == K_LAST) ? '0 : k + 1'b1;
          end
        end
        S_EMIT: begin
          if (emit_adv) begin
            if (pv) count_q <= count_q + 1'b1;
            ptr <= ptr + 1'b1;
            if (ptr == PTR_LAST) seg_base <= base_nx[N_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_segmented_sieve.sv
// Directed bench for segmented_sieve: stream contents, counts, backpressure,
// illegal ranges and mid-run reset.
module tb_segmented_sieve;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  segmented_sieve_if #(.N_W(14)) bus ();

  segmented_sieve #(
    .N_W(14), .MAX_N(10000), .SEG_LEN(64), .P_W(7), .NUM_BASE(25)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int got[$];
  bit saw_valid, saw_done, err_at_done;
  int cnt_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_stream(input int l, input int h);
    int exp_q[$];
    for (int n = l; n <= h; n++) if (is_prime(n)) exp_q.push_back(n);
    check("stream_len", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("prime[%0d]", i), (i < got.size()) ? got[i] : 0, exp_q[i]);
  endtask

  // mode 0: ready always high; 1: random ready; 2: hold ready low 5 cycles at first valid
  task automatic do_run(input int l, input int h, input int mode,
                        input int exp_cnt, input bit exp_err);
    int  cyc;
    int  hold;
    bit  r;
    got.delete();
    saw_valid = 0; saw_done = 0; err_at_done = 0; cnt_at_done = -1;
    hold = 0;
    @(negedge clk);
    bus.lo = 14'(l); bus.hi = 14'(h); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    cyc = 0;
    while (!saw_done && cyc < 60000) begin
      r = 1'b1;
      if (mode == 1) r = 1'($urandom_range(0, 1));
      if (mode == 2 && bus.prime_valid && hold < 5) begin
        r = 1'b0;
        check("bp_data_held", bus.prime_data, 2);
        check("bp_count_held", bus.count, 0);
        hold++;
      end
      bus.prime_ready = r;
      if (bus.prime_valid) saw_valid = 1;
      if (bus.prime_valid && r) got.push_back(int'(bus.prime_data));
      if (bus.done) begin
        saw_done    = 1;
        err_at_done = bus.err;
        cnt_at_done = int'(bus.count);
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    bus.prime_ready = 1'b0;
    check("done_seen", saw_done, 1);
    check("count_at_done", cnt_at_done, exp_cnt);
    check("err_at_done", err_at_done, exp_err);
    @(negedge clk);
    check("busy_after_done", bus.busy, 0);
    check("done_one_cycle", bus.done, 0);
    check("count_held", bus.count, exp_cnt);
    if (exp_err) check("no_valid_on_err", saw_valid, 0);
    else         check_stream(l, h);
    if (mode == 2) check("bp_hold_cycles", hold, 5);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    bus.start = 1'b0; bus.lo = '0; bus.hi = '0; bus.prime_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  bus.busy, 0);
    check("rst_valid", bus.prime_valid, 0);
    check("rst_done",  bus.done, 0);
    check("rst_err",   bus.err, 0);
    check("rst_count", bus.count, 0);
    check("rst_data",  bus.prime_data, 0);
    rst = 1'b0;

    do_run(2, 30, 0, 10, 0);
    check("p30_last", got.size() == 10 ? got[9] : 0, 29);

    do_run(2, 70, 0, 19, 0);
    check("seg_cross_a", got.size() == 19 ? got[17] : 0, 61);
    check("seg_cross_b", got.size() == 19 ? got[18] : 0, 67);

    do_run(90, 110, 0, 5, 0);
    check("p90_first", got.size() == 5 ? got[0] : 0, 97);
    check("p90_last",  got.size() == 5 ? got[4] : 0, 109);

    do_run(9990, 10000, 0, 0, 0);
    do_run(7, 7, 0, 1, 0);
    do_run(8, 8, 0, 0, 0);

    do_run(2, 10, 2, 4, 0);

    do_run(50, 40, 0, 0, 1);
    do_run(2, 10001, 0, 0, 1);

    do_run(2, 10000, 1, 1229, 0);

    // Reset in the middle of streaming
    @(negedge clk);
    bus.lo = 14'd2; bus.hi = 14'd1000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.prime_ready = 1'b1;
    cyc = 0;
    while (!(bus.prime_valid && bus.count >= 14'd5) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("midrun_reached", bus.prime_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", bus.prime_valid, 0);
    check("midrst_busy",  bus.busy, 0);
    check("midrst_count", bus.count, 0);
    rst = 1'b0; bus.prime_ready = 1'b0;
    do_run(2, 30, 0, 10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/segmented_sieve.md
Name: segmented_sieve

Overview:
- Parametrised successor to the fixed-window sieve: a streaming prime generator over a run-time range [lo, hi].
- Works one SEG_LEN-bit segment at a time, which avoids a full-width bitmap.
- Each base prime keeps a persistent next-multiple register that carries across segment boundaries.
- Found primes leave in ascending order on a valid/ready stream; a done pulse and prime count follow. Sits beside the prime-test logic as its range-query engine.

Parameters:
- N_W, 14, width of lo/hi/prime_data/count.
- MAX_N, 10000, largest legal hi; must be < (next prime after the largest base prime)^2.
- SEG_LEN, 64, bits per segment bitmap (power of 2).
- P_W, 7, width of one base-prime entry.
- NUM_BASE, 25, number of base primes.
- BASE_PRIMES, primes 2..97 packed, entry k at bits [k*P_W +: P_W], ascending.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- lo  in  N_W  range low bound, latched on accepted start
- hi  in  N_W  range high bound, latched on accepted start
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- prime_valid  out  1  prime_data holds a prime
- prime_ready  in  1  consumer accepts when valid&ready
- prime_data  out  N_W  prime value
- done  out  1  one-cycle pulse at end of run
- err  out  1  valid with done; illegal range
- count  out  N_W  primes emitted in last run; held until next accepted start

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (any state, including mid-run): state = IDLE; busy, prime_valid, done and err = 0; count = 0; prime_data = 0; bitmap and offsets are don't-care.
- States: IDLE -> MOD -> SEG_INIT -> SIEVE -> EMIT -> (SEG_INIT | DONE) -> IDLE.
- IDLE, accepted start: latch lo and hi; count <= 0; seg_base <= lo.
- Illegal range (lo > hi or hi > MAX_N): go straight to DONE with err = 1; no stream output.
- start during busy is ignored.
- MOD, for each prime p (k = 0..NUM_BASE-1):
  - Serial restoring division, N_W cycles, computes r = lo mod p.
  - One more cycle writes next[k] = p*p if lo <= p*p, else lo + (r == 0 ? 0 : p - r).
  - next[k] is N_W+1 bits wide so it cannot overflow.
  - Total MOD time: NUM_BASE*(N_W+1) cycles.
- SEG_INIT (1 cycle):
  - seg_end = min(seg_base + SEG_LEN - 1, hi).
  - bitmap <= all ones, then clear bits for values < 2 and values > seg_end.
- SIEVE, for k in order:
  - While next[k] <= seg_end: clear bit next[k] - seg_base and set next[k] += p, one mark per cycle.
  - When next[k] > seg_end: one cycle to advance k.
  - next[k] is never reset between segments.
- EMIT: scan pointer ptr runs 0..SEG_LEN-1, one position per cycle.
  - Set bit: prime_valid = 1, prime_data = seg_base + ptr.
  - Data stays stable and ptr stalls while !prime_ready.
  - On handshake: count += 1 and ptr advances. Back-to-back handshakes allowed (1 prime/cycle).
  - Clear bits are skipped at 1 cycle each.
- End of EMIT:
  - seg_base += SEG_LEN.
  - If the new seg_base > hi, or the addition overflows N_W, go to DONE; otherwise go to SEG_INIT.
- DONE (1 cycle): done = 1, busy = 1, count final. Then IDLE with busy = 0.
- lo == hi is legal: emits 0 or 1 prime.
- A range shorter than SEG_LEN uses a single segment.

Test Plan:
- lo=2, hi=30 -> stream 2,3,5,7,11,13,17,19,23,29; done with count=10, err=0.
- lo=2, hi=70, SEG_LEN=64 (crosses a segment boundary) -> 19 primes, last 61 then 67; no duplicates or gaps at 65/66; count=19.
- lo=90, hi=110 -> 97,101,103,107,109, count=5. Also lo=9990, hi=10000 -> no valid, done, count=0.
- Backpressure:
  - lo=2, hi=10, prime_ready low 5 cycles while prime_valid=1, prime_data=2 -> data held at 2; no count change until accept; final count=4.
  - Randomly toggled ready on lo=2, hi=10000 -> 1229 primes in order, count=1229.
- Illegal: lo=50, hi=40 -> done=1, err=1, count=0, prime_valid never 1. Also hi=10001 -> same.
- Reset mid-EMIT of lo=2, hi=1000 -> next cycle prime_valid=0, busy=0, count=0; a following start with lo=2, hi=30 yields count=10.
